// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-cycle logic/arith ops plus iterative unsigned multiply and divide.
// Define SEQ_ALU_DIV_EN to compile in the DIVU/REMU datapath; otherwise those opcodes complete as illegal.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_cnt,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               sel_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;
  logic               divz_q;

  logic [WIDTH-1:0]   simple_res;
  logic               simple_ill;
  logic               is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   step_res;

  assign is_mul = (alu_cnt == OP_MUL) || (alu_cnt == OP_MULHU);

  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    case (alu_cnt)
      OP_AND:  simple_res = src_a & src_b;
      OP_OR:   simple_res = src_a | src_b;
      OP_ADD:  simple_res = src_a + src_b;
      OP_SUB:  simple_res = src_a - src_b;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: simple_ill = 1'b1;
    endcase
  end

  // acc_q holds {partial product high, remaining multiplier bits}; shift right each step
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic           is_div;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign is_div = (alu_cnt == OP_DIVU) || (alu_cnt == OP_REMU);

  // acc_q holds {remainder, dividend/quotient}; a zero divisor naturally yields all-ones and src_a
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    step_next = (state_q == DIV) ? div_next : mul_next;
  end
`else
  always_comb begin
    step_next = mul_next;
  end
`endif

  // High half serves MULHU and REMU, low half MUL and DIVU
  assign step_res = sel_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q <= alu_cnt[0];
            cnt_q <= CW'(WIDTH - 1);
            if (is_mul) begin
              state_q <= MUL;
              busy_q  <= 1'b1;
              acc_q   <= {{WIDTH{1'b0}}, src_b};
              opnd_q  <= src_a;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (is_div) begin
              state_q <= DIV;
              busy_q  <= 1'b1;
              acc_q   <= {{WIDTH{1'b0}}, src_a};
              opnd_q  <= src_b;
            end
`endif
            else begin
              result_q  <= simple_res;
              zero_q    <= (simple_res == '0);
              illegal_q <= simple_ill;
              divz_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          acc_q <= step_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= step_res;
            zero_q    <= (step_res == '0);
            illegal_q <= 1'b0;
            divz_q    <= (state_q == DIV) && (opnd_q == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign illegal    = illegal_q;
  assign div_zero   = divz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32; expectations are queued at issue and popped on done.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_cnt;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         illegal;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    logic         dz;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   last_done_cyc = -1;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_cnt    (alu_cnt),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .zero       (zero),
    .illegal    (illegal),
    .div_zero   (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_done: done=1 with nothing pending, alu_result=%h", alu_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (alu_result !== e.res) begin
          errors++;
          $display("[TB] FAIL %s result: got %h expected %h", e.name, alu_result, e.res);
        end
        checks++;
        if (zero !== (e.res == '0)) begin
          errors++;
          $display("[TB] FAIL %s zero: got %b expected %b", e.name, zero, (e.res == '0));
        end
        checks++;
        if (illegal !== e.ill) begin
          errors++;
          $display("[TB] FAIL %s illegal: got %b expected %b", e.name, illegal, e.ill);
        end
        checks++;
        if (div_zero !== e.dz) begin
          errors++;
          $display("[TB] FAIL %s div_zero: got %b expected %b", e.name, div_zero, e.dz);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ei, input logic ed, input string name);
    exp_t e;
    @(negedge clk);
    start = 1'b1; alu_cnt = op; src_a = a; src_b = b;
    issue_cyc = cyc;
    e.res = er; e.ill = ei; e.dz = ed; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0; alu_cnt = 4'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  // Latency is counted in clock edges from the negedge the request was driven on
  task automatic wait_drain(input string name, input int exp_lat);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s timeout: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end else if (last_done_cyc - issue_cyc !== exp_lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, last_done_cyc - issue_cyc, exp_lat);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({busy, done, alu_result, zero, illegal, div_zero} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s: got busy=%b done=%b res=%h zero=%b ill=%b dz=%b expected 0 0 0 1 0 0",
               name, busy, done, alu_result, zero, illegal, div_zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; alu_cnt = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_add_sub();
    issue(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add_5_7");
    drop_start();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_busy: got %b expected 0", busy);
    end
    wait_drain("add_5_7", 1);
    issue(4'b0110, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0, "sub_7_7");
    drop_start();
    wait_drain("sub_7_7", 1);
    issue(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_wrap");
    drop_start();
    wait_drain("sub_wrap", 1);
  endtask

  task automatic test_slt();
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, "slt_neg_pos");
    drop_start();
    wait_drain("slt_neg_pos", 1);
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "slt_pos_neg");
    drop_start();
    wait_drain("slt_pos_neg", 1);
  endtask

  task automatic test_mul();
    logic [2*W-1:0] p;
    logic [W-1:0]   a, b;
    issue(4'b1000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, "mul_lo");
    drop_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mul_busy: got %b expected 1", busy);
    end
    repeat (8) @(negedge clk);
    start = 1'b1; alu_cnt = 4'b0010; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("mul_lo", W + 1);
    issue(4'b1001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 1'b0, "mulhu");
    drop_start();
    wait_drain("mulhu", W + 1);
    a = $urandom; b = $urandom;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    issue(4'b1001, a, b, p[2*W-1:W], 1'b0, 1'b0, "mulhu_rand");
    drop_start();
    wait_drain("mulhu_rand", W + 1);
    issue(4'b1000, a, b, p[W-1:0], 1'b0, 1'b0, "mul_rand");
    drop_start();
    wait_drain("mul_rand", W + 1);
  endtask

  task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
    logic [W-1:0] a, b;
    issue(4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, "divu_100_7");
    drop_start();
    wait_drain("divu_100_7", W + 1);
    issue(4'b1011, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, "remu_100_7");
    drop_start();
    wait_drain("remu_100_7", W + 1);
    issue(4'b1010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, "divu_by_zero");
    drop_start();
    wait_drain("divu_by_zero", W + 1);
    issue(4'b1011, 32'd5, 32'd0, 32'd5, 1'b0, 1'b1, "remu_by_zero");
    drop_start();
    wait_drain("remu_by_zero", W + 1);
    a = $urandom; b = ($urandom >> 8) | 32'd1;
    issue(4'b1010, a, b, a / b, 1'b0, 1'b0, "divu_rand");
    drop_start();
    wait_drain("divu_rand", W + 1);
    issue(4'b1011, a, b, a % b, 1'b0, 1'b0, "remu_rand");
    drop_start();
    wait_drain("remu_rand", W + 1);
`else
    issue(4'b1010, 32'd100, 32'd7, 32'd0, 1'b1, 1'b0, "divu_disabled");
    drop_start();
    wait_drain("divu_disabled", 1);
    issue(4'b1011, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, "remu_disabled");
    drop_start();
    wait_drain("remu_disabled", 1);
`endif
  endtask

  task automatic test_illegal();
    issue(4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, "op_1111");
    drop_start();
    wait_drain("op_1111", 1);
    issue(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "illegal_cleared");
    drop_start();
    wait_drain("illegal_cleared", 1);
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, 4)];
      a = $urandom; b = $urandom;
      case (op)
        4'b0000: r = a & b;
        4'b0001: r = a | b;
        4'b0010: r = a + b;
        4'b0110: r = a - b;
        default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      issue(op, a, b, r, 1'b0, 1'b0, "b2b_single");
    end
    drop_start();
    wait_drain("b2b_single", 1);
    issue(4'b1000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, "mul_then_add");
    drop_start();
    repeat (W - 1) @(negedge clk);
    issue(4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, "add_in_done_cycle");
    drop_start();
    wait_drain("add_in_done_cycle", 1);
  endtask

  task automatic test_reset_mid_op();
    issue(4'b0010, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0, "pre_abort_add");
    drop_start();
    wait_drain("pre_abort_add", 1);
    issue(4'b1000, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, "aborted_mul");
    drop_start();
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    check_reset_values("abort_no_done");
    issue(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, "add_after_abort");
    drop_start();
    wait_drain("add_after_abort", 1);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
